vc_sram_arb_1rw: RTL and testbench
==================================

VC_SRAM_ARB_1RW -- requirements
Module: vc_sram_arb_1rw

Interface
REQ-001 SHALL have parameter p_data_nbits, default 32, SRAM word width.
REQ-002 SHALL have parameter p_num_entries, default 256, SRAM depth; c_addr_nbits = $clog2(p_num_entries), c_data_nbytes = (p_data_nbits+7)/8.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have, for N in {0,1}, port inN_req_val, input, 1, request valid.
REQ-006 SHALL have inN_req_rdy, output, 1, request accepted when val&&rdy.
REQ-007 SHALL have inN_req_type, input, 1, 0 = read, 1 = write.
REQ-008 SHALL have inN_req_addr, input, c_addr_nbits, word address.
REQ-009 SHALL have inN_req_data, input, p_data_nbits, write data, and inN_req_byte_en, input, c_data_nbytes, write byte enables.
REQ-010 SHALL have inN_resp_val, output, 1; inN_resp_rdy, input, 1; inN_resp_data, output, p_data_nbits, response channel.

Function
REQ-011 SHALL share one internal synchronous 1rw SRAM (one-cycle read latency, byte-enabled writes) between the two requesters, one transaction in flight at a time.
REQ-012 SHALL implement FSM states IDLE, READ, RESP.
REQ-013 IDLE: req_rdy SHALL be high only for the granted port, and only when its req_val is high; other port's req_rdy low.
REQ-014 Grant SHALL be round-robin: if only one port valid, grant it; if both valid, grant port indicated by priority pointer.
REQ-015 Pointer SHALL move to the non-granted port after every accepted request; unchanged when nothing accepted.
REQ-016 Accepted read: SRAM read_en asserted in the accept cycle with req_addr; next state READ.
REQ-017 READ: SRAM read_data SHALL be captured into a response register; next state RESP.
REQ-018 Accepted write: SRAM write_en asserted in accept cycle with addr/data/byte_en; read_en and write_en never both high.
REQ-019 RESP: resp_val high only to the owning port, resp_data stable from register; on resp_rdy go IDLE; hold indefinitely while resp_rdy low.
REQ-020 Read latency: resp_val SHALL rise two cycles after the accept edge; back-to-back throughput one read per 3 cycles minimum.
REQ-021 Read after write to same address SHALL return written bytes (merged with prior contents for disabled bytes).
REQ-022 SRAM enables SHALL be low in READ and RESP; no new request accepted outside IDLE.
REQ-023 inN_resp_val SHALL never be high for both ports simultaneously.

Reset
REQ-024 Reset SHALL force state IDLE, pointer to port 0, both resp_val low, both req_rdy low, resp register zero; SRAM contents are not reset.
REQ-025 Reset asserted mid-transaction SHALL abort it; a pending response is dropped, a write accepted at the asserting edge is not guaranteed.

Configuration
REQ-026 Macro VC_SRAM_ARB_WRITE_ACK_EN defined: accepted write SHALL go to RESP (skipping READ) with resp_data all zero, one cycle after accept.
REQ-027 Macro undefined: accepted write SHALL produce no response and FSM stays IDLE, allowing a new accept next cycle.

Structure
REQ-028 Package vc_sram_arb_pkg SHALL hold FSM state enum and request-type constants (REQ_RD = 0, REQ_WR = 1).
REQ-029 Sole sub-module SHALL be vc_SynchronousSRAM_1rw instantiated with p_data_nbits/p_num_entries; arbitration and FSM stay in this module.

Verification
REQ-030 Port 0 write addr 5 data 32'hDEADBEEF byte_en 4'hF, then read addr 5 -> resp_data 32'hDEADBEEF on in0, two cycles after read accept.
REQ-031 Both ports read at same cycle after reset -> port 0 served first, port 1 next; repeat -> port 1 first on the following contention.
REQ-032 Write 32'hFFFFFFFF, then byte_en 4'b0010 data 32'h00000000 to same addr, read -> 32'hFFFF00FF.
REQ-033 Hold in1_resp_rdy low 10 cycles during RESP -> resp_val and data stable, in0_req_rdy low throughout.
REQ-034 Write with VC_SRAM_ARB_WRITE_ACK_EN -> one resp_val with data 0; without -> no resp_val, next request accepted next cycle.
REQ-035 Assert reset while in READ -> next cycle all resp_val low, state IDLE, pointer at port 0.

Source files
------------

// File: rtl/vc_sram_arb_pkg.sv
// Shared definitions for the two-port 1rw SRAM arbiter: FSM state encoding
// and request-type constants.
package vc_sram_arb_pkg;

   // FSM state enumeration, kept as plain constants so legacy tools can use them
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_READ = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   // Request type carried on inN_req_type
   localparam logic REQ_RD = 1'b0;
   localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/vc_sram_arb_if.sv
// Request/response bundle for one requester of the SRAM arbiter.
// master = requester side, slave = arbiter side.
interface vc_sram_arb_if #(
   parameter int p_data_nbits  = 32,
   parameter int p_num_entries = 256
);
   localparam int c_addr_nbits  = $clog2(p_num_entries);
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8;

   logic                     req_val;
   logic                     req_rdy;
   logic                     req_type;
   logic [c_addr_nbits-1:0]  req_addr;
   logic [p_data_nbits-1:0]  req_data;
   logic [c_data_nbytes-1:0] req_byte_en;
   logic                     resp_val;
   logic                     resp_rdy;
   logic [p_data_nbits-1:0]  resp_data;

   modport master (
      output req_val, req_type, req_addr, req_data, req_byte_en, resp_rdy,
      input  req_rdy, resp_val, resp_data
   );

   modport slave (
      input  req_val, req_type, req_addr, req_data, req_byte_en, resp_rdy,
      output req_rdy, resp_val, resp_data
   );

endinterface

// File: rtl/vc_SynchronousSRAM_1rw.sv
// Single-port synchronous SRAM: one-cycle registered read, byte-enabled write.
// The caller guarantees read_en and write_en are never high together.
module vc_SynchronousSRAM_1rw #(
   parameter int p_data_nbits  = 32,
   parameter int p_num_entries = 256,
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     read_en,
   input  logic [c_addr_nbits-1:0]  read_addr,
   output logic [p_data_nbits-1:0]  read_data,
   input  logic                     write_en,
   input  logic [c_data_nbytes-1:0] write_byte_en,
   input  logic [c_addr_nbits-1:0]  write_addr,
   input  logic [p_data_nbits-1:0]  write_data
);

   logic [p_data_nbits-1:0] mem_q [p_num_entries];
   logic [p_data_nbits-1:0] read_data_q;
   logic [p_data_nbits-1:0] bit_mask;

   // Expand byte enables to a per-bit mask (handles a partial top byte)
   for (genvar i = 0; i < p_data_nbits; i++) begin : g_mask
      assign bit_mask[i] = write_byte_en[i/8];
   end

   // Array write with byte merge, and registered read port
   // NOTE: the storage array has no reset; clearing every word would defeat
   // SRAM inference, and contents after power-up are defined as don't-care.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem_q[write_addr] <= (mem_q[write_addr] & ~bit_mask) | (write_data & bit_mask);
      end
      if (read_en) begin
         read_data_q <= mem_q[read_addr];
      end
   end

   assign read_data = read_data_q;

endmodule

// File: rtl/vc_sram_arb_1rw.sv
// Two-requester round-robin arbiter in front of one synchronous 1rw SRAM.
// One transaction in flight at a time: IDLE -> READ -> RESP for reads.
// Optional macro VC_SRAM_ARB_WRITE_ACK_EN: writes return a zero-data response
// (IDLE -> RESP); when undefined, writes are silent and the FSM stays in IDLE.
module vc_sram_arb_1rw
   import vc_sram_arb_pkg::*;
#(
   parameter int p_data_nbits  = 32,
   parameter int p_num_entries = 256,
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     in0_req_val,
   output logic                     in0_req_rdy,
   input  logic                     in0_req_type,
   input  logic [c_addr_nbits-1:0]  in0_req_addr,
   input  logic [p_data_nbits-1:0]  in0_req_data,
   input  logic [c_data_nbytes-1:0] in0_req_byte_en,
   output logic                     in0_resp_val,
   input  logic                     in0_resp_rdy,
   output logic [p_data_nbits-1:0]  in0_resp_data,

   input  logic                     in1_req_val,
   output logic                     in1_req_rdy,
   input  logic                     in1_req_type,
   input  logic [c_addr_nbits-1:0]  in1_req_addr,
   input  logic [p_data_nbits-1:0]  in1_req_data,
   input  logic [c_data_nbytes-1:0] in1_req_byte_en,
   output logic                     in1_resp_val,
   input  logic                     in1_resp_rdy,
   output logic [p_data_nbits-1:0]  in1_resp_data
);

   state_t                   state_q, state_d;
   logic                     ptr_q, ptr_d;       // port holding priority on contention
   logic                     owner_q, owner_d;   // port owning the in-flight transaction
   logic [p_data_nbits-1:0]  resp_data_q, resp_data_d;

   logic                     gnt0, gnt1, accept, sel, sel_type, owner_resp_rdy;
   logic [c_addr_nbits-1:0]  sel_addr;
   logic [p_data_nbits-1:0]  sel_data;
   logic [c_data_nbytes-1:0] sel_byte_en;
   logic                     sram_read_en, sram_write_en;
   logic [p_data_nbits-1:0]  sram_read_data;

   // Round-robin grant, ready generation and request mux toward the SRAM
   always_comb begin
      gnt0        = in0_req_val && (!in1_req_val || !ptr_q);
      gnt1        = in1_req_val && (!in0_req_val ||  ptr_q);
      in0_req_rdy = (state_q == ST_IDLE) && !reset && gnt0;
      in1_req_rdy = (state_q == ST_IDLE) && !reset && gnt1;
      accept      = in0_req_rdy || in1_req_rdy;
      sel         = in1_req_rdy;
      sel_type    = sel ? in1_req_type    : in0_req_type;
      sel_addr    = sel ? in1_req_addr    : in0_req_addr;
      sel_data    = sel ? in1_req_data    : in0_req_data;
      sel_byte_en = sel ? in1_req_byte_en : in0_req_byte_en;
      sram_read_en  = accept && (sel_type == REQ_RD);
      sram_write_en = accept && (sel_type == REQ_WR);
   end

   // Response channel: only the owning port sees resp_val
   always_comb begin
      in0_resp_val   = (state_q == ST_RESP) && !owner_q;
      in1_resp_val   = (state_q == ST_RESP) &&  owner_q;
      in0_resp_data  = resp_data_q;
      in1_resp_data  = resp_data_q;
      owner_resp_rdy = owner_q ? in1_resp_rdy : in0_resp_rdy;
   end

   // FSM next state, pointer rotation and response capture
   // NOTE: every signal gets its hold value first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      resp_data_d = resp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               ptr_d   = ~sel;
               owner_d = sel;
               if (sel_type == REQ_RD) begin
                  state_d = ST_READ;
               end else begin
`ifdef VC_SRAM_ARB_WRITE_ACK_EN
                  state_d     = ST_RESP;
                  resp_data_d = '0;
`else
                  state_d     = ST_IDLE;
`endif
               end
            end
         end
         ST_READ: begin
            resp_data_d = sram_read_data;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (owner_resp_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous reset
   // NOTE: non-blocking assignments so every flop samples pre-edge values,
   // independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         resp_data_q <= resp_data_d;
      end
   end

   vc_SynchronousSRAM_1rw #(
      .p_data_nbits  (p_data_nbits),
      .p_num_entries (p_num_entries)
   ) u_sram (
      .clk           (clk),
      .read_en       (sram_read_en),
      .read_addr     (sel_addr),
      .read_data     (sram_read_data),
      .write_en      (sram_write_en),
      .write_byte_en (sel_byte_en),
      .write_addr    (sel_addr),
      .write_data    (sel_data)
   );

endmodule

// File: tb/tb_vc_sram_arb_1rw.sv
// Self-checking bench for vc_sram_arb_1rw: table of write/read vectors plus
// hand-written sequences for latency, contention, backpressure and reset.
module tb_vc_sram_arb_1rw;
   import vc_sram_arb_pkg::*;

   logic clk;
   logic reset;

   vc_sram_arb_if #(.p_data_nbits(32), .p_num_entries(256)) if0 ();
   vc_sram_arb_if #(.p_data_nbits(32), .p_num_entries(256)) if1 ();

   vc_sram_arb_1rw #(.p_data_nbits(32), .p_num_entries(256)) dut (
      .clk             (clk),
      .reset           (reset),
      .in0_req_val     (if0.req_val),
      .in0_req_rdy     (if0.req_rdy),
      .in0_req_type    (if0.req_type),
      .in0_req_addr    (if0.req_addr),
      .in0_req_data    (if0.req_data),
      .in0_req_byte_en (if0.req_byte_en),
      .in0_resp_val    (if0.resp_val),
      .in0_resp_rdy    (if0.resp_rdy),
      .in0_resp_data   (if0.resp_data),
      .in1_req_val     (if1.req_val),
      .in1_req_rdy     (if1.req_rdy),
      .in1_req_type    (if1.req_type),
      .in1_req_addr    (if1.req_addr),
      .in1_req_data    (if1.req_data),
      .in1_req_byte_en (if1.req_byte_en),
      .in1_resp_val    (if1.resp_val),
      .in1_resp_rdy    (if1.resp_rdy),
      .in1_resp_data   (if1.resp_data)
   );

   typedef struct {
      bit          port;
      bit          typ;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      bit          port;
      logic [31:0] data;
   } exp_t;

   vec_t vecs [12];
   exp_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input bit port, input bit val, input bit typ, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
      if (port) begin
         if1.req_val = val; if1.req_type = typ; if1.req_addr = addr;
         if1.req_data = data; if1.req_byte_en = be;
      end else begin
         if0.req_val = val; if0.req_type = typ; if0.req_addr = addr;
         if0.req_data = data; if0.req_byte_en = be;
      end
   endtask

   function automatic logic rdy(input bit port);
      return port ? if1.req_rdy : if0.req_rdy;
   endfunction

   task automatic push_exp(input bit port, input logic [31:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Drive one request, wait (bounded) for acceptance, then drop val.
   // Entered and left at posedge+1.
   task automatic issue(input bit port, input bit typ, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input bit push, input logic [31:0] exp);
      bit got = 1'b0;
      if (push && typ == REQ_RD) push_exp(port, exp);
`ifdef VC_SRAM_ARB_WRITE_ACK_EN
      if (push && typ == REQ_WR) push_exp(port, 32'h0);
`endif
      set_req(port, 1'b1, typ, addr, data, be);
      #1;
      for (int i = 0; i < 40; i++) begin
         if (rdy(port)) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("issue_accept", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
      set_req(port, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
   endtask

   task automatic wait_any_rdy();
      for (int i = 0; i < 40; i++) begin
         if (if0.req_rdy || if1.req_rdy) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", exp_q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic score(input bit port, input logic [31:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_resp: got port %0d data %h, expected no response", port, data);
      end else begin
         e = exp_q.pop_front();
         check("resp_port", {31'b0, port}, {31'b0, e.port});
         check("resp_data", data, e.data);
      end
   endtask

   // Response monitor: pops the scoreboard on every response handshake
   always @(negedge clk) begin
      if (!reset) begin
         if (if0.resp_val || if1.resp_val)
            check("resp_val_onehot", {31'b0, if0.resp_val && if1.resp_val}, 32'd0);
         if (if0.resp_val && if0.resp_rdy) score(1'b0, if0.resp_data);
         if (if1.resp_val && if1.resp_rdy) score(1'b1, if1.resp_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b0, REQ_WR, 8'd5,   32'hDEADBEEF, 4'hF,    32'h0};
      vecs[1]  = '{1'b0, REQ_RD, 8'd5,   32'h0,        4'h0,    32'hDEADBEEF};
      vecs[2]  = '{1'b1, REQ_WR, 8'd9,   32'hFFFFFFFF, 4'hF,    32'h0};
      vecs[3]  = '{1'b1, REQ_WR, 8'd9,   32'h00000000, 4'b0010, 32'h0};
      vecs[4]  = '{1'b1, REQ_RD, 8'd9,   32'h0,        4'h0,    32'hFFFF00FF};
      vecs[5]  = '{1'b0, REQ_WR, 8'd0,   32'h12345678, 4'hF,    32'h0};
      vecs[6]  = '{1'b1, REQ_WR, 8'd255, 32'hA5A5A5A5, 4'hF,    32'h0};
      vecs[7]  = '{1'b0, REQ_WR, 8'd255, 32'h00C30000, 4'b0100, 32'h0};
      vecs[8]  = '{1'b1, REQ_RD, 8'd0,   32'h0,        4'h0,    32'h12345678};
      vecs[9]  = '{1'b0, REQ_RD, 8'd255, 32'h0,        4'h0,    32'hA5C3A5A5};
      vecs[10] = '{1'b0, REQ_WR, 8'd5,   32'h00000011, 4'b0001, 32'h0};
      vecs[11] = '{1'b1, REQ_RD, 8'd5,   32'h0,        4'h0,    32'hDEADBE11};

      // Reset state, with both requesters asserting val
      reset = 1'b1;
      if0.resp_rdy = 1'b1;
      if1.resp_rdy = 1'b1;
      set_req(1'b0, 1'b1, REQ_RD, 8'd1, 32'h0, 4'h0);
      set_req(1'b1, 1'b1, REQ_RD, 8'd2, 32'h0, 4'h0);
      #2;
      check("rst_req_rdy0",  {31'b0, if0.req_rdy},  32'd0);
      check("rst_req_rdy1",  {31'b0, if1.req_rdy},  32'd0);
      check("rst_resp_val0", {31'b0, if0.resp_val}, 32'd0);
      check("rst_resp_val1", {31'b0, if1.resp_val}, 32'd0);
      check("rst_resp_data", if0.resp_data, 32'h0);
      check("rst_state",     {30'b0, dut.state_q},  {30'b0, ST_IDLE});
      check("rst_ptr",       {31'b0, dut.ptr_q},    32'd0);
      set_req(1'b0, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      set_req(1'b1, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Table-driven write/read vectors
      for (int i = 0; i < 12; i++)
         issue(vecs[i].port, vecs[i].typ, vecs[i].addr, vecs[i].data, vecs[i].be, 1'b1, vecs[i].exp);
      drain();

      // Write handling and read latency
      set_req(1'b0, 1'b1, REQ_WR, 8'd7, 32'h0BADF00D, 4'hF);
`ifdef VC_SRAM_ARB_WRITE_ACK_EN
      push_exp(1'b0, 32'h0);
`endif
      #1;
      check("wr_rdy0", {31'b0, if0.req_rdy}, 32'd1);
      @(posedge clk); #1;
`ifdef VC_SRAM_ARB_WRITE_ACK_EN
      set_req(1'b0, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      check("wr_ack_val",  {31'b0, if0.resp_val}, 32'd1);
      check("wr_ack_data", if0.resp_data, 32'h0);
      @(posedge clk); #1;
`else
      check("no_wr_resp0", {31'b0, if0.resp_val}, 32'd0);
      check("no_wr_resp1", {31'b0, if1.resp_val}, 32'd0);
`endif
      set_req(1'b0, 1'b1, REQ_RD, 8'd7, 32'h0, 4'h0);
      push_exp(1'b0, 32'h0BADF00D);
      #1;
      check("rd_next_rdy0", {31'b0, if0.req_rdy}, 32'd1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      check("lat_cycle1_val", {31'b0, if0.resp_val}, 32'd0);
      @(posedge clk); #1;
      check("lat_cycle2_val",  {31'b0, if0.resp_val}, 32'd1);
      check("lat_cycle2_data", if0.resp_data, 32'h0BADF00D);
      drain();

      // Round-robin contention from a fresh reset (SRAM keeps its data)
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, REQ_RD, 8'd0,   32'h0, 4'h0);
      set_req(1'b1, 1'b1, REQ_RD, 8'd255, 32'h0, 4'h0);
      push_exp(1'b0, 32'h12345678);
      push_exp(1'b1, 32'hA5C3A5A5);
      push_exp(1'b0, 32'hFFFF00FF);
      #1;
      check("cont1_rdy0", {31'b0, if0.req_rdy}, 32'd1);
      check("cont1_rdy1", {31'b0, if1.req_rdy}, 32'd0);
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, REQ_RD, 8'd9, 32'h0, 4'h0);
      wait_any_rdy();
      check("cont2_rdy1", {31'b0, if1.req_rdy}, 32'd1);
      check("cont2_rdy0", {31'b0, if0.req_rdy}, 32'd0);
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      wait_any_rdy();
      check("cont3_rdy0", {31'b0, if0.req_rdy}, 32'd1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      drain();

      // Response backpressure on port 1 while port 0 waits
      if1.resp_rdy = 1'b0;
      issue(1'b1, REQ_RD, 8'd9, 32'h0, 4'h0, 1'b1, 32'hFFFF00FF);
      set_req(1'b0, 1'b1, REQ_RD, 8'd0, 32'h0, 4'h0);
      push_exp(1'b0, 32'h12345678);
      for (int i = 0; i < 10 && !if1.resp_val; i++) begin
         @(posedge clk); #1;
      end
      check("bp_val_seen", {31'b0, if1.resp_val}, 32'd1);
      for (int c = 0; c < 10; c++) begin
         check("bp_val1",  {31'b0, if1.resp_val}, 32'd1);
         check("bp_data1", if1.resp_data, 32'hFFFF00FF);
         check("bp_rdy0",  {31'b0, if0.req_rdy},  32'd0);
         check("bp_val0",  {31'b0, if0.resp_val}, 32'd0);
         @(posedge clk); #1;
      end
      if1.resp_rdy = 1'b1;
      for (int i = 0; i < 10 && !if0.req_rdy; i++) begin
         @(posedge clk); #1;
      end
      check("bp_p0_accept", {31'b0, if0.req_rdy}, 32'd1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, REQ_RD, 8'd0, 32'h0, 4'h0);
      drain();

      // Reset while in READ drops the pending response
      issue(1'b0, REQ_RD, 8'd0, 32'h0, 4'h0, 1'b0, 32'h0);
      check("rst_mid_pre_state", {30'b0, dut.state_q}, {30'b0, ST_READ});
      check("rst_mid_pre_ptr",   {31'b0, dut.ptr_q},   32'd1);
      reset = 1'b1;
      #1;
      check("rst_mid_val0",  {31'b0, if0.resp_val}, 32'd0);
      check("rst_mid_val1",  {31'b0, if1.resp_val}, 32'd0);
      check("rst_mid_state", {30'b0, dut.state_q},  {30'b0, ST_IDLE});
      check("rst_mid_ptr",   {31'b0, dut.ptr_q},    32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("rst_mid_quiet_val0", {31'b0, if0.resp_val}, 32'd0);
      issue(1'b1, REQ_RD, 8'd9, 32'h0, 4'h0, 1'b1, 32'hFFFF00FF);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
